ecc_op_sequencer: RTL and testbench

// - APB slave register file plus operation sequencer in front of the ECC enc/dec core.
// - Holds CTRL/DATA_IN/CODEWORD_WIDTH/NOISE, launches one core operation per CTRL write,

---
 rtl/ecc_seq_pkg.sv | 39 +++
 rtl/ecc_apb_regs.sv | 82 ++++++++
 rtl/ecc_op_sequencer.sv | 126 ++++++++++++
 tb/tb_ecc_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_seq_pkg.sv
// Shared encodings for the ECC operation sequencer: FSM states, register map,
// operation/width codes and the abort error code.
package ecc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_DATA_IN = 5'h04;
  localparam logic [4:0] OFF_WIDTH   = 5'h08;
  localparam logic [4:0] OFF_NOISE   = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;

  // CTRL[1:0]: reserved code is treated as encode by the core
  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // CODEWORD_WIDTH[1:0]: both upper codes select 32-bit codewords
  localparam logic [1:0] WIDTH_8   = 2'b00;
  localparam logic [1:0] WIDTH_16  = 2'b01;
  localparam logic [1:0] WIDTH_32  = 2'b10;
  localparam logic [1:0] WIDTH_32B = 2'b11;

  localparam logic [1:0] ERR_ABORT = 2'b11;

  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_DROPPED = 1;
  localparam int unsigned STATUS_TIMEOUT = 2;

  // Wide enough for any timeout in 1..15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ecc_apb_regs.sv
// APB register file for the ECC sequencer: decode, storage, read mux and
// the two W1C sticky status flags.
module ecc_apb_regs
  import ecc_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        paddr,
  input  logic [WORD_W-1:0] pwdata,
  input  logic              penable,
  input  logic              psel,
  input  logic              pwrite,
  output logic [WORD_W-1:0] prdata_c,
  output logic              ctrl_wr_c,
  input  logic              busy_c,
  input  logic              set_dropped_c,
  input  logic              set_timeout_c,
  output logic [1:0]        width_q,
  output logic [WORD_W-1:0] data_in_q,
  output logic [WORD_W-1:0] noise_q
);

  logic       wr_en_c;
  logic       clr_dropped_c;
  logic       clr_timeout_c;
  logic [1:0] ctrl_q;
  logic       dropped_q;
  logic       timeout_q;

  assign wr_en_c       = psel && penable && pwrite;
  assign ctrl_wr_c     = wr_en_c && (paddr == OFF_CTRL);
  assign clr_dropped_c = wr_en_c && (paddr == OFF_STATUS) && pwdata[STATUS_DROPPED];
  assign clr_timeout_c = wr_en_c && (paddr == OFF_STATUS) && pwdata[STATUS_TIMEOUT];

  // Writable registers; unused high bits are simply not stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      width_q   <= '0;
      data_in_q <= '0;
      noise_q   <= '0;
    end else if (wr_en_c) begin
      unique case (paddr)
        OFF_CTRL:    ctrl_q    <= pwdata[1:0];
        OFF_DATA_IN: data_in_q <= pwdata;
        OFF_WIDTH:   width_q   <= pwdata[1:0];
        OFF_NOISE:   noise_q   <= pwdata;
        default:     ;
      endcase
    end
  end

  // Sticky flags: a hardware set beats a simultaneous W1C
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropped_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_dropped_c)      dropped_q <= 1'b1;
      else if (clr_dropped_c) dropped_q <= 1'b0;
      if (set_timeout_c)      timeout_q <= 1'b1;
      else if (clr_timeout_c) timeout_q <= 1'b0;
    end
  end

  always_comb begin
    prdata_c = '0;
    if (psel && !pwrite) begin
      unique case (paddr)
        OFF_CTRL:    prdata_c = WORD_W'(ctrl_q);
        OFF_DATA_IN: prdata_c = data_in_q;
        OFF_WIDTH:   prdata_c = WORD_W'(width_q);
        OFF_NOISE:   prdata_c = noise_q;
        OFF_STATUS:  prdata_c = WORD_W'({timeout_q, dropped_q, busy_c});
        default:     prdata_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/ecc_op_sequencer.sv
// APB-fronted operation sequencer for the ECC core: one launch per accepted
// CTRL write, bounded wait for the core result, registered result and done pulse.
module ecc_op_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       core_start,
  output logic [1:0]                 core_op,
  output logic [1:0]                 core_width,
  output logic [AMBA_WORD-1:0]       core_data,
  output logic [AMBA_WORD-1:0]       core_noise,
  input  logic                       core_valid,
  input  logic [AMBA_WORD-1:0]       core_data_out,
  input  logic [1:0]                 core_num_err,
  output logic [AMBA_WORD-1:0]       data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e           state;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 ctrl_wr_c;
  logic                 busy_c;
  logic                 set_dropped_c;
  logic                 set_timeout_c;
  logic [1:0]           width_q;
  logic [AMBA_WORD-1:0] data_in_q;
  logic [AMBA_WORD-1:0] noise_q;
  logic                 paddr_unused;

  // Only the low five address bits select a register
  assign paddr_unused = ^PADDR[AMBA_ADDR_WIDTH-1:5];
  assign PREADY       = 1'b1;

  assign busy_c        = (state != ST_IDLE);
  assign set_dropped_c = ctrl_wr_c && busy_c;
  assign set_timeout_c = (state == ST_WAIT) && !core_valid && (wait_cnt == CNT_LAST);

  ecc_apb_regs #(
    .WORD_W (AMBA_WORD)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .paddr         (PADDR[4:0]),
    .pwdata        (PWDATA),
    .penable       (PENABLE),
    .psel          (PSEL),
    .pwrite        (PWRITE),
    .prdata_c      (PRDATA),
    .ctrl_wr_c     (ctrl_wr_c),
    .busy_c        (busy_c),
    .set_dropped_c (set_dropped_c),
    .set_timeout_c (set_timeout_c),
    .width_q       (width_q),
    .data_in_q     (data_in_q),
    .noise_q       (noise_q)
  );

  // Sequencer FSM; the op code comes from the bus since CTRL commits on this same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      core_start     <= 1'b0;
      core_op        <= '0;
      core_width     <= '0;
      core_data      <= '0;
      core_noise     <= '0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
    end else begin
      core_start     <= 1'b0;
      operation_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ctrl_wr_c) begin
            state      <= ST_LAUNCH;
            core_start <= 1'b1;
            core_op    <= PWDATA[1:0];
            core_width <= width_q;
            core_data  <= data_in_q;
            core_noise <= noise_q;
          end
        end
        ST_LAUNCH: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (core_valid) begin
            state         <= ST_DONE;
            data_out      <= core_data_out;
            num_of_errors <= core_num_err;
          end else if (wait_cnt == CNT_LAST) begin
            state         <= ST_DONE;
            data_out      <= '0;
            num_of_errors <= ERR_ABORT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          operation_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer: a cycle-indexed transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ecc_op_sequencer;

  localparam int TO    = 6;
  localparam int NEVER = 32'h7fff_ffff;
  localparam logic [14:0] AHI = 15'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PENABLE, PSEL, PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        core_start;
  logic [1:0]  core_op, core_width;
  logic [31:0] core_data, core_noise;
  logic        core_valid;
  logic [31:0] core_data_out;
  logic [1:0]  core_num_err;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;

  ecc_op_sequencer #(
    .AMBA_ADDR_WIDTH (20),
    .AMBA_WORD       (32),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PENABLE        (PENABLE),
    .PSEL           (PSEL),
    .PWRITE         (PWRITE),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .core_start     (core_start),
    .core_op        (core_op),
    .core_width     (core_width),
    .core_data      (core_data),
    .core_noise     (core_noise),
    .core_valid     (core_valid),
    .core_data_out  (core_data_out),
    .core_num_err   (core_num_err),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: register contents, accepted operation timing and results
  logic [1:0]  reg_ctrl, reg_width, m_op, m_width, m_res_err, m_out_err, v_err;
  logic [31:0] reg_data, reg_noise, m_data, m_noise, m_res_data, m_out_data, v_data;
  int m_launch, m_done, valid_at, to_from, dr_from;

  task automatic model_reset();
    reg_ctrl = '0; reg_width = '0; reg_data = '0; reg_noise = '0;
    m_op = '0; m_width = '0; m_data = '0; m_noise = '0;
    m_res_data = '0; m_res_err = '0; m_out_data = '0; m_out_err = '0;
    v_data = '0; v_err = '0;
    m_launch = -1; m_done = -1; valid_at = -1;
    to_from = NEVER; dr_from = NEVER;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic busy;
    busy = (m_launch >= 0) && (cyc >= m_launch) && (cyc < m_done);
    case (a)
      5'h00:   return {30'd0, reg_ctrl};
      5'h04:   return reg_data;
      5'h08:   return {30'd0, reg_width};
      5'h0C:   return reg_noise;
      5'h10:   return {29'd0, cyc >= to_from, cyc >= dr_from, busy};
      default: return 32'd0;
    endcase
  endfunction

  // Core responder: asserts core_valid for the one scheduled cycle
  always @(posedge clk) begin
    #1;
    core_valid    = (valid_at >= 0) && (cyc == valid_at);
    core_data_out = v_data;
    core_num_err  = v_err;
  end

  // Every-cycle comparison against the model while out of reset
  always @(negedge clk) begin
    if (rst) begin
      if (m_done >= 0 && cyc >= m_done) begin
        m_out_data = m_res_data;
        m_out_err  = m_res_err;
      end
      check("core_start", 32'(core_start), 32'(cyc == m_launch));
      check("operation_done", 32'(operation_done), 32'(cyc == m_done));
      check("core_op", 32'(core_op), 32'(m_op));
      check("core_width", 32'(core_width), 32'(m_width));
      check("core_data", core_data, m_data);
      check("core_noise", core_noise, m_noise);
      check("PREADY", 32'(PREADY), 32'd1);
      check("PRDATA", PRDATA, (PSEL && !PWRITE) ? model_read(PADDR[4:0]) : 32'd0);
      if (!((m_launch >= 0) && (cyc >= m_launch) && (cyc < m_done))) begin
        check("data_out", data_out, m_out_data);
        check("num_of_errors", 32'(num_of_errors), 32'(m_out_err));
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two-phase APB write; t is the edge at which it commits
  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output int t);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {AHI, a}; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    case (a)
      5'h00: reg_ctrl  = d[1:0];
      5'h04: reg_data  = d;
      5'h08: reg_width = d[1:0];
      5'h0C: reg_noise = d;
      5'h10: begin
        if (d[1] && dr_from < t) dr_from = NEVER;
        if (d[2] && to_from < t) to_from = NEVER;
      end
      default: ;
    endcase
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {AHI, a};
    @(posedge clk); #1;
    PENABLE = 1'b1;
    d = PRDATA;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // CTRL write; k = WAIT cycle of core_valid (k >= TO means the core never answers)
  task automatic do_ctrl(input logic [1:0] op, input int k, input logic [31:0] rd,
                         input logic [1:0] re, output int t);
    apb_write(5'h00, {30'd0, op}, t);
    if (t > m_done) begin
      m_launch = t; m_op = op; m_width = reg_width; m_data = reg_data; m_noise = reg_noise;
      if (k < TO) begin
        valid_at = t + 1 + k; v_data = rd; v_err = re;
        m_done = t + 3 + k; m_res_data = rd; m_res_err = re;
      end else begin
        m_done = t + 2 + TO; m_res_data = 32'd0; m_res_err = 2'b11;
        if (t + 1 + TO < to_from) to_from = t + 1 + TO;
      end
    end else if (t < dr_from) begin
      dr_from = t;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".core_start"}, 32'(core_start), 32'd0);
    check({tag, ".operation_done"}, 32'(operation_done), 32'd0);
    check({tag, ".data_out"}, data_out, 32'd0);
    check({tag, ".num_of_errors"}, 32'(num_of_errors), 32'd0);
    check({tag, ".core_op"}, 32'(core_op), 32'd0);
    check({tag, ".core_width"}, 32'(core_width), 32'd0);
    check({tag, ".core_data"}, core_data, 32'd0);
    check({tag, ".core_noise"}, core_noise, 32'd0);
  endtask

  initial begin
    int t, t2;
    logic [31:0] rd;
    model_reset();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    core_valid = 1'b0; core_data_out = '0; core_num_err = '0;

    // Power-on reset
    #2;
    check_all_zero("reset");
    check("reset.PRDATA", PRDATA, 32'd0);
    check("reset.PREADY", 32'(PREADY), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Encode: result in WAIT cycle 1, done pulse four edges after CTRL commit
    apb_write(5'h04, 32'h0000_00A5, t);
    apb_write(5'h08, 32'h0, t);
    do_ctrl(2'b00, 1, 32'h0000_01A5, 2'd0, t);
    check("enc.core_start", 32'(core_start), 32'd1);
    check("enc.core_data", core_data, 32'h0000_00A5);
    wait_to(t + 3);
    check("enc.done_early", 32'(operation_done), 32'd0);
    wait_to(t + 4);
    check("enc.done", 32'(operation_done), 32'd1);
    check("enc.data_out", data_out, 32'h0000_01A5);
    check("enc.nerr", 32'(num_of_errors), 32'd0);

    // Register readback and unmapped address
    apb_write(5'h04, 32'hDEAD_BEEF, t);
    apb_write(5'h08, 32'h0000_0007, t);
    apb_write(5'h0C, 32'h0000_0100, t);
    apb_read(5'h04, rd); check("rb.data_in", rd, 32'hDEAD_BEEF);
    apb_read(5'h08, rd); check("rb.width", rd, 32'h0000_0003);
    apb_read(5'h14, rd); check("rb.unmapped", rd, 32'h0);

    // Decode with earliest result: done three edges after commit
    do_ctrl(2'b01, 0, 32'h1234_5678, 2'd1, t);
    check("dec.core_op", 32'(core_op), 32'd1);
    check("dec.core_width", 32'(core_width), 32'd3);
    check("dec.core_noise", core_noise, 32'h0000_0100);
    wait_to(t + 3);
    check("dec.done", 32'(operation_done), 32'd1);
    check("dec.nerr", 32'(num_of_errors), 32'd1);
    wait_to(t + 5);

    // Timeout while STATUS is held on the read bus
    do_ctrl(2'b01, 99, 32'h0, 2'd0, t);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {AHI, 5'h10};
    wait_to(t + 3);
    check("to.status_wait", PRDATA, 32'h1);
    wait_to(t + 7);
    check("to.status_done", PRDATA, 32'h5);
    wait_to(t + 8);
    check("to.done", 32'(operation_done), 32'd1);
    check("to.nerr", 32'(num_of_errors), 32'd3);
    check("to.data_out", data_out, 32'h0);
    check("to.status_after", PRDATA, 32'h4);
    PSEL = 1'b0;
    apb_write(5'h10, 32'h4, t);
    apb_read(5'h10, rd); check("to.w1c", rd, 32'h0);

    // Second CTRL write two edges later is dropped
    do_ctrl(2'b10, 2, 32'h0000_0F0F, 2'd2, t);
    do_ctrl(2'b11, 0, 32'h0, 2'd0, t2);
    wait_to(t + 6);
    apb_read(5'h10, rd); check("drop.status", rd, 32'h2);
    apb_read(5'h00, rd); check("drop.ctrl", rd, 32'h3);
    apb_write(5'h10, 32'h2, t);
    apb_read(5'h10, rd); check("drop.w1c", rd, 32'h0);

    // Result on the last WAIT cycle beats the timeout
    do_ctrl(2'b00, TO - 1, 32'h0000_CAFE, 2'd2, t);
    wait_to(t + 2 + TO);
    check("race.done", 32'(operation_done), 32'd1);
    check("race.nerr", 32'(num_of_errors), 32'd2);
    check("race.data_out", data_out, 32'h0000_CAFE);
    wait_to(t + 3 + TO);

    // CTRL write landing in the DONE cycle is dropped, the next one launches
    do_ctrl(2'b00, 0, 32'h0000_0055, 2'd0, t);
    wait_to(t + 1);
    do_ctrl(2'b01, 0, 32'h0, 2'd0, t2);
    check("donedrop.commit_edge", 32'(t2 - t), 32'd3);
    do_ctrl(2'b01, 1, 32'h0000_0077, 2'd1, t2);
    wait_to(t2 + 5);
    apb_read(5'h10, rd); check("donedrop.status", rd, 32'h2);
    check("donedrop.data_out", data_out, 32'h0000_0077);

    // core_valid while idle is ignored
    v_data = 32'h0000_0BAD; v_err = 2'd2; valid_at = cyc + 1;
    wait_to(cyc + 4);
    check("idlevalid.data_out", data_out, 32'h0000_0077);

    // Reset in the middle of WAIT
    do_ctrl(2'b00, 99, 32'h0, 2'd0, t);
    wait_to(t + 3);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {AHI, 5'h10};
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    check("midrst.status", PRDATA, 32'h0);
    PSEL = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    wait_to(cyc + TO + 4);
    apb_read(5'h10, rd); check("midrst.status_after", rd, 32'h0);
    apb_read(5'h04, rd); check("midrst.data_in", rd, 32'h0);

    wait_to(cyc + 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
